cmos_dvp_capture: RTL

// - OV5640 8-bit DVP receiver in the cmos_pclk domain, upstream of the pixel FIFO feeding the 800x480 HDMI path.
// - Pairs bytes into RGB565 pixels and discards the first SKIP_FRAMES frames while the sensor settles.
// - Counts pixels per line and lines per frame, and raises sticky error flags.
// - Produces the cmos_vsync/cmos_href-derived qualifiers that the debug probes sample.

---
 rtl/cmos_cap_pkg.sv | 17 +
 rtl/cmos_sync_edge.sv | 30 +++
 rtl/cmos_dvp_capture.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/cmos_cap_pkg.sv
// Shared types and widths for the DVP capture block: FSM states, RGB565 layout, counter sizes.
package cmos_cap_pkg;

    typedef enum logic [1:0] {
        SYNC_WAIT = 2'd0,
        SKIP      = 2'd1,
        CAPTURE   = 2'd2
    } cap_state_e;

    localparam int R_W   = 5;
    localparam int G_W   = 6;
    localparam int B_W   = 5;
    localparam int PIX_W = R_W + G_W + B_W;
    localparam int X_W   = 11;
    localparam int Y_W   = 10;

endpackage

// File: rtl/cmos_sync_edge.sv
// One-stage input register with polarity normalisation and a single edge detector (RISE selects which edge).
// Latency: act_o one cycle after the pin; edge_o valid in the same cycle as the act_o transition.
module cmos_sync_edge #(
    parameter bit ACT_HIGH = 1'b1,
    parameter bit RISE     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic sig_i,
    output logic act_o,
    output logic edge_o
);

    logic act_q;
    logic prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            act_q  <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            act_q  <= sig_i ~^ ACT_HIGH;
            prev_q <= act_q;
        end
    end

    assign act_o  = act_q;
    assign edge_o = RISE ? (act_q & ~prev_q) : (~act_q & prev_q);

endmodule

// File: rtl/cmos_dvp_capture.sv
// OV5640 8-bit DVP receiver: pairs bytes into RGB565, drops settling frames, checks line/frame geometry.
// Pixel strobe lands 2 cmos_pclk after the low byte; fifo_full drops pixels (sticky fifo_ovf), never stalls.
module cmos_dvp_capture
    import cmos_cap_pkg::*;
#(
    parameter int H_ACTIVE    = 800,
    parameter int V_ACTIVE    = 480,
    parameter int SKIP_FRAMES = 10,
    parameter bit VSYNC_POL   = 1'b1
) (
    input  logic             cmos_pclk,
    input  logic             rst,
    input  logic             cmos_vsync,
    input  logic             cmos_href,
    input  logic [7:0]       cmos_data,
    input  logic             fifo_full,
    input  logic             clr_err,
    output logic             pix_valid,
    output logic [PIX_W-1:0] pix_data,
    output logic             frame_start,
    output logic             frame_done,
    output logic [Y_W-1:0]   y_cnt,
    output logic             capturing,
    output logic             line_err,
    output logic             frame_err,
    output logic             fifo_ovf
);

    localparam int SK_W = (SKIP_FRAMES > 1) ? $clog2(SKIP_FRAMES) : 1;

    logic vs_act, vs_rise, href_act, href_fall;

    cmos_sync_edge #(.ACT_HIGH(VSYNC_POL), .RISE(1'b1)) u_vs_edge (
        .clk    (cmos_pclk),
        .rst    (rst),
        .sig_i  (cmos_vsync),
        .act_o  (vs_act),
        .edge_o (vs_rise)
    );

    cmos_sync_edge #(.ACT_HIGH(1'b1), .RISE(1'b0)) u_href_edge (
        .clk    (cmos_pclk),
        .rst    (rst),
        .sig_i  (cmos_href),
        .act_o  (href_act),
        .edge_o (href_fall)
    );

    cap_state_e       state_q, state_d;
    logic [SK_W-1:0]  skip_q, skip_d;
    logic [7:0]       data_q, hi_q, hi_d;
    logic             phase_q, phase_d;
    logic             in_line_q;
    logic [X_W-1:0]   x_q, x_d;
    logic [Y_W-1:0]   y_q, y_d, y_eff;
    logic             pix_vld_q, pix_vld_d;
    logic [PIX_W-1:0] pix_dat_q, pix_dat_d;
    logic             fs_pend_q, fs_pend_d;
    logic             fstart_q, fstart_d;
    logic             fdone_q, fdone_d;
    logic             line_err_q, line_err_d;
    logic             frame_err_q, frame_err_d;
    logic             ovf_q, ovf_d;
    logic             line_set, frame_set, ovf_set;
    logic             line_act, line_end;

    // A line byte is only accepted outside vsync; in_line_q lets a line that ends on a vs_rise still count.
    assign line_act = href_act & ~vs_act;
    assign line_end = href_fall & in_line_q;

    always_comb begin
        state_d   = state_q;
        skip_d    = skip_q;
        hi_d      = hi_q;
        phase_d   = 1'b0;
        x_d       = x_q;
        y_d       = y_q;
        y_eff     = y_q;
        pix_vld_d = 1'b0;
        pix_dat_d = pix_dat_q;
        fs_pend_d = fs_pend_q;
        fstart_d  = 1'b0;
        fdone_d   = 1'b0;
        line_set  = 1'b0;
        frame_set = 1'b0;
        ovf_set   = 1'b0;

        if (line_act) begin
            phase_d = ~phase_q;
            if (!phase_q) begin
                hi_d = data_q;
            end
        end

        unique case (state_q)
            SYNC_WAIT: begin
                if (vs_rise) begin
                    if (SKIP_FRAMES == 0) begin
                        state_d   = CAPTURE;
                        fs_pend_d = 1'b1;
                    end else begin
                        state_d = SKIP;
                        skip_d  = '0;
                    end
                end
            end
            SKIP: begin
                if (vs_rise) begin
                    if (skip_q == SK_W'(SKIP_FRAMES - 1)) begin
                        state_d   = CAPTURE;
                        fs_pend_d = 1'b1;
                    end else begin
                        skip_d = skip_q + 1'b1;
                    end
                end
            end
            CAPTURE: begin
                if (line_act && phase_q) begin
                    x_d = x_q + 1'b1;
                    if (fifo_full) begin
                        ovf_set = 1'b1;
                    end else begin
                        pix_vld_d = 1'b1;
                        pix_dat_d = {hi_q, data_q};
                        fstart_d  = fs_pend_q;
                        fs_pend_d = 1'b0;
                    end
                end
                if (line_end) begin
                    x_d      = '0;
                    line_set = (x_q != X_W'(H_ACTIVE)) || phase_q;
                    y_eff    = (y_q == '1) ? y_q : y_q + 1'b1;
                    y_d      = y_eff;
                end
                // The line closed on this cycle (if any) is already folded into y_eff.
                if (vs_rise) begin
                    if (y_eff == Y_W'(V_ACTIVE)) begin
                        fdone_d = 1'b1;
                    end else if (y_eff != '0) begin
                        frame_set = 1'b1;
                    end
                    y_d       = '0;
                    fs_pend_d = 1'b1;
                end
            end
            default: state_d = SYNC_WAIT;
        endcase

        line_err_d  = (line_err_q & ~clr_err) | line_set;
        frame_err_d = (frame_err_q & ~clr_err) | frame_set;
        ovf_d       = (ovf_q & ~clr_err) | ovf_set;
    end

    always_ff @(posedge cmos_pclk) begin
        if (rst) begin
            state_q     <= SYNC_WAIT;
            skip_q      <= '0;
            data_q      <= '0;
            hi_q        <= '0;
            phase_q     <= 1'b0;
            in_line_q   <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            pix_vld_q   <= 1'b0;
            pix_dat_q   <= '0;
            fs_pend_q   <= 1'b0;
            fstart_q    <= 1'b0;
            fdone_q     <= 1'b0;
            line_err_q  <= 1'b0;
            frame_err_q <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            skip_q      <= skip_d;
            data_q      <= cmos_data;
            hi_q        <= hi_d;
            phase_q     <= phase_d;
            in_line_q   <= line_act;
            x_q         <= x_d;
            y_q         <= y_d;
            pix_vld_q   <= pix_vld_d;
            pix_dat_q   <= pix_dat_d;
            fs_pend_q   <= fs_pend_d;
            fstart_q    <= fstart_d;
            fdone_q     <= fdone_d;
            line_err_q  <= line_err_d;
            frame_err_q <= frame_err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign pix_valid   = pix_vld_q;
    assign pix_data    = pix_dat_q;
    assign frame_start = fstart_q;
    assign frame_done  = fdone_q;
    assign y_cnt       = y_q;
    assign capturing   = (state_q == CAPTURE);
    assign line_err    = line_err_q;
    assign frame_err   = frame_err_q;
    assign fifo_ovf    = ovf_q;

endmodule
